// File: rtl/scan_pkg.sv
// Shared scan-mode encodings for the LED scanner and anything that drives it.
package scan_pkg;

  typedef enum logic [1:0] {
    BOUNCE    = 2'd0,
    WRAP_UP   = 2'd1,
    WRAP_DOWN = 2'd2,
    BAR       = 2'd3
  } scan_mode_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a single-cycle tick every period+1 enabled cycles, on the
// same clock as everything else (no derived clock).
module tick_gen #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;

  // >= so that shrinking period below the running count fires immediately
  assign tick = en && (cnt >= period);

  always_ff @(posedge clock) begin
    if (!rst)      cnt <= '0;
    else if (tick) cnt <= '0;
    else if (en)   cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/led_scanner.sv
// LED scanner: steps a position across N_LEDS outputs in one of four scan
// modes, paced by tick_gen. Mode is only looked at on step edges.
module led_scanner
  import scan_pkg::*;
#(
  parameter int N_LEDS = 10,
  parameter int CNT_W  = 32
) (
  input  logic                      MAX10_CLK1_50,
  input  logic                      rst,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic [CNT_W-1:0]          period,
  output logic [N_LEDS-1:0]         LEDR,
  output logic [$clog2(N_LEDS)-1:0] pos,
  output logic                      dir,
  output logic                      step,
  output logic                      end_hit
);

  localparam int PW = $clog2(N_LEDS);
  localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);

  if (N_LEDS < 2 || N_LEDS > 32) begin : g_bad_n_leds
    $error("led_scanner: N_LEDS must be within 2..32");
  end

  logic              tick;
  logic [PW-1:0]     pos_nxt;
  logic              dir_nxt;
  logic [N_LEDS-1:0] led_nxt;
  scan_mode_e        mode_e;

  assign mode_e = scan_mode_e'(mode);

  tick_gen #(.CNT_W(CNT_W)) u_tick (
    .clock  (MAX10_CLK1_50),
    .rst    (rst),
    .en     (en),
    .period (period),
    .tick   (tick)
  );

  // Next position/direction; ends reflect without dwelling.
  always_comb begin
    pos_nxt = pos;
    dir_nxt = dir;
    unique case (mode_e)
      WRAP_UP: begin
        dir_nxt = 1'b1;
        pos_nxt = (pos == LAST) ? '0 : pos + PW'(1);
      end
      WRAP_DOWN: begin
        dir_nxt = 1'b0;
        pos_nxt = (pos == '0) ? LAST : pos - PW'(1);
      end
      default: begin
        if (dir) begin
          if (pos == LAST) begin
            dir_nxt = 1'b0;
            pos_nxt = LAST - PW'(1);
          end else begin
            pos_nxt = pos + PW'(1);
          end
        end else begin
          if (pos == '0) begin
            dir_nxt = 1'b1;
            pos_nxt = PW'(1);
          end else begin
            pos_nxt = pos - PW'(1);
          end
        end
      end
    endcase
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_led
    assign led_nxt[i] = (mode_e == BAR) ? (PW'(i) <= pos_nxt) : (PW'(i) == pos_nxt);
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!rst) begin
      pos     <= '0;
      dir     <= 1'b1;
      LEDR    <= N_LEDS'(1);
      step    <= 1'b0;
      end_hit <= 1'b0;
    end else begin
      step    <= tick;
      end_hit <= tick && (pos_nxt == '0 || pos_nxt == LAST);
      if (tick) begin
        pos  <= pos_nxt;
        dir  <= dir_nxt;
        LEDR <= led_nxt;
      end
    end
  end

endmodule

// File: doc/led_scanner.md
LED_SCANNER -- requirements
Module: led_scanner

Interface
REQ-001 SHALL have parameter N_LEDS, default 10, number of scanned LEDs; legal range 2..32, elaboration error otherwise.
REQ-002 SHALL have parameter CNT_W, default 32, width of the prescaler counter and period input.
REQ-003 SHALL have port MAX10_CLK1_50  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  input  1  run enable; 0 = pause with all state held.
REQ-006 SHALL have port mode  input  2  scan mode: 0 BOUNCE, 1 WRAP_UP, 2 WRAP_DOWN, 3 BAR.
REQ-007 SHALL have port period  input  CNT_W  step interval minus one, in clock cycles.
REQ-008 SHALL have port LEDR  output  N_LEDS  LED pattern.
REQ-009 SHALL have port pos  output  $clog2(N_LEDS)  current position index.
REQ-010 SHALL have port dir  output  1  current direction (1 = up, toward N_LEDS-1).
REQ-011 SHALL have port step  output  1  one-cycle pulse, high in the first cycle a new pos is visible.
REQ-012 SHALL have port end_hit  output  1  one-cycle pulse coincident with step when the new pos is 0 or N_LEDS-1.

Function
REQ-013 SHALL run the prescaler only while en=1: if cnt >= period then cnt <= 0 and a step fires on that edge, else cnt <= cnt+1.
REQ-014 SHALL step every period+1 cycles while en=1; period=0 steps every cycle.
REQ-015 SHALL compare with >= so lowering period below the current cnt fires a step on the next edge.
REQ-016 SHALL hold cnt, pos, dir and LEDR, and keep step/end_hit low, while en=0.
REQ-017 SHALL, in BOUNCE and BAR: up step pos+1; at pos=N_LEDS-1 with dir=1 set dir=0 and pos=N_LEDS-2 in the same step; at pos=0 with dir=0 set dir=1 and pos=1; no dwell at the ends.
REQ-018 SHALL, in WRAP_UP: force dir=1; pos N_LEDS-1 -> 0.
REQ-019 SHALL, in WRAP_DOWN: force dir=0; pos 0 -> N_LEDS-1.
REQ-020 SHALL sample mode only on step edges; a mode change takes effect at the next step, and forced dir is applied in that same step.
REQ-021 SHALL drive LEDR = one-hot (1 << pos) in modes 0-2, and bits [pos:0] set in BAR; LEDR is registered and updates on the same edge as pos.
REQ-022 SHALL never let pos leave 0..N_LEDS-1, including on mode changes at the ends.

Reset
REQ-023 SHALL, when rst=0 at a clock edge, set cnt=0, pos=0, dir=1, LEDR=1, step=0, end_hit=0, regardless of en, mode or period.
REQ-024 SHALL start the first step period+1 cycles after the first edge with rst=1 and en=1.
REQ-025 SHALL abandon any partially counted interval on reset mid-operation.

Structure
REQ-026 SHALL place the mode encodings (BOUNCE, WRAP_UP, WRAP_DOWN, BAR) in a shared package, scan_pkg.
REQ-027 SHALL implement the prescaler as sub-module tick_gen (ports: clock, rst, en, period, tick), replacing any derived-clock scheme; the design has a single clock domain.

Verification
REQ-028 N_LEDS=10, period=3, mode=BOUNCE, en=1 after reset -> step every 4 cycles; pos 0,1..9,8..0,1; end_hit with pos 9 and pos 0; LEDR=10'h200 at pos 9.
REQ-029 mode=WRAP_UP, period=0 -> pos increments every cycle; 9 -> 0 with end_hit; mode switched to WRAP_DOWN at pos 5 -> next pos 4, dir=0.
REQ-030 BAR, period=1 -> LEDR 10'h001, 10'h003, 10'h007 ... 10'h3FF, then 10'h1FF on the way down.
REQ-031 en dropped for 20 cycles at cnt=2, period=5 -> no step, pos/LEDR/cnt frozen; first step 4 cycles after en returns.
REQ-032 period changed from 100 to 2 when cnt=50 -> step on next edge, then every 3 cycles.
REQ-033 rst=0 for one cycle at pos 7, dir=0 -> next cycle pos=0, dir=1, LEDR=10'h001, step=0; scan resumes after period+1 cycles.
